// File: rtl/testdrive_virtual_slave_regbank.sv
// testdrive_virtual_slave_regbank: BFM-facing register bank with ID/CTRL/IRQ/scratch regs and a command FIFO.
// Optional free-running cycle counter at 0x005 when TESTDRIVE_VIRTUAL_SLAVE_REGBANK_CYCLE_EN is defined.
module testdrive_virtual_slave_regbank #(
  parameter int          C_ADDR_BITS   = 10,
  parameter logic [31:0] C_ID          = 32'h5244_0001,
  parameter int          C_SCRATCH_CNT = 8,
  parameter int          C_FIFO_DEPTH  = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   WE,
  input  logic [C_ADDR_BITS-1:0] WADDR,
  input  logic [31:0]            WDATA,
  input  logic                   RE,
  input  logic [C_ADDR_BITS-1:0] RADDR,
  output logic [31:0]            RDATA,
  input  logic [7:0]             IRQ_SET,
  output logic                   IRQ,
  output logic [31:0]            CTRL,
  output logic                   CMD_VALID,
  output logic [31:0]            CMD_DATA,
  input  logic                   CMD_READY
);
  localparam int PW = $clog2(C_FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [C_ADDR_BITS-1:0] A_ID = C_ADDR_BITS'(0);
  localparam logic [C_ADDR_BITS-1:0] A_CTRL = C_ADDR_BITS'(1);
  localparam logic [C_ADDR_BITS-1:0] A_STATUS = C_ADDR_BITS'(2);
  localparam logic [C_ADDR_BITS-1:0] A_IS = C_ADDR_BITS'(3);
  localparam logic [C_ADDR_BITS-1:0] A_IM = C_ADDR_BITS'(4);
  localparam logic [C_ADDR_BITS-1:0] A_CYC = C_ADDR_BITS'(5);
  localparam logic [C_ADDR_BITS-1:0] A_PUSH = C_ADDR_BITS'(6);

  logic [31:0]   ctrl, status, rd_mux, cycle_rd;
  logic [7:0]    irq_status, irq_mask;
  logic          ovf, irq, full, pop, push_req, push, ovf_set, w_scr, r_scr;
  logic [PW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic [31:0]   mem [C_FIFO_DEPTH];
  // Sized for the maximum scratch count; entries beyond C_SCRATCH_CNT are never written.
  logic [31:0]   scratch [16];

  assign full      = level == LW'(C_FIFO_DEPTH);
  assign CMD_VALID = level != '0;
  assign CMD_DATA  = mem[rptr];
  assign CTRL      = ctrl;
  assign IRQ       = irq;
  assign pop       = CMD_VALID && CMD_READY;
  assign push_req  = WE && WADDR == A_PUSH;
  assign push      = push_req && (!full || pop);
  assign ovf_set   = push_req && full && !pop;
  assign w_scr     = WE && WADDR[C_ADDR_BITS-1:4] == (C_ADDR_BITS-4)'(1) && {1'b0, WADDR[3:0]} < 5'(C_SCRATCH_CNT);
  assign r_scr     = RADDR[C_ADDR_BITS-1:4] == (C_ADDR_BITS-4)'(1) && {1'b0, RADDR[3:0]} < 5'(C_SCRATCH_CNT);

  always_comb begin
    status = '0;
    status[0] = !CMD_VALID;
    status[1] = full;
    status[2] = ovf;
    status[3] = irq;
    status[8 +: LW] = level;
  end

  always_comb begin
    rd_mux = '0;
    case (RADDR)
      A_ID:     rd_mux = C_ID;
      A_CTRL:   rd_mux = ctrl;
      A_STATUS: rd_mux = status;
      A_IS:     rd_mux = {24'h0, irq_status};
      A_IM:     rd_mux = {24'h0, irq_mask};
      A_CYC:    rd_mux = cycle_rd;
      default:  rd_mux = r_scr ? scratch[RADDR[3:0]] : '0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ctrl <= '0;
      irq_status <= '0;
      irq_mask <= '0;
      ovf <= 1'b0;
      irq <= 1'b0;
      RDATA <= '0;
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      for (int i = 0; i < 16; i++) scratch[i] <= '0;
      for (int i = 0; i < C_FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (WE && WADDR == A_CTRL) ctrl <= WDATA;
      if (WE && WADDR == A_IM) irq_mask <= WDATA[7:0];
      // Set pulses are OR-ed in after the W1C so a same-cycle set wins.
      irq_status <= (irq_status & ~((WE && WADDR == A_IS) ? WDATA[7:0] : 8'h0)) | IRQ_SET;
      ovf <= (ovf && !(WE && WADDR == A_STATUS && WDATA[2])) || ovf_set;
      irq <= |(irq_status & irq_mask);
      if (RE) RDATA <= rd_mux;
      if (w_scr) scratch[WADDR[3:0]] <= WDATA;
      if (push) begin
        mem[wptr] <= WDATA;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

`ifdef TESTDRIVE_VIRTUAL_SLAVE_REGBANK_CYCLE_EN
  logic [31:0] cycle;
  assign cycle_rd = cycle;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cycle <= '0;
    else cycle <= (WE && WADDR == A_CYC) ? 32'h0 : cycle + 32'h1;
  end
`else
  assign cycle_rd = '0;
`endif
endmodule

// File: tb/tb_testdrive_virtual_slave_regbank.sv
// tb_testdrive_virtual_slave_regbank: directed vector table plus reset and cycle-counter sequences.
module tb_testdrive_virtual_slave_regbank;
  logic        CLK = 1'b0, nRST = 1'b0, WE = 1'b0, RE = 1'b0, CMD_READY = 1'b0;
  logic [9:0]  WADDR = '0, RADDR = '0;
  logic [31:0] WDATA = '0, RDATA, CTRL, CMD_DATA;
  logic [7:0]  IRQ_SET = '0;
  logic        IRQ, CMD_VALID;
  int          errors = 0, checks = 0;

  testdrive_virtual_slave_regbank dut (
    .CLK(CLK), .nRST(nRST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .RE(RE), .RADDR(RADDR),
    .RDATA(RDATA), .IRQ_SET(IRQ_SET), .IRQ(IRQ), .CTRL(CTRL), .CMD_VALID(CMD_VALID),
    .CMD_DATA(CMD_DATA), .CMD_READY(CMD_READY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [9:0]  raddr;
    logic [7:0]  irq_set;
    logic        ready;
    logic [31:0] exp_rdata;
    logic        exp_irq;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [31:0] exp_ctrl;
  } vec_t;

  vec_t tv [34];

  function automatic vec_t v(logic we, logic [9:0] wa, logic [31:0] wd, logic re, logic [9:0] ra,
                             logic [7:0] is, logic rdy, logic [31:0] er, logic ei, logic ev,
                             logic [31:0] ed, logic [31:0] ec);
    vec_t r;
    r.we = we; r.waddr = wa; r.wdata = wd; r.re = re; r.raddr = ra; r.irq_set = is; r.ready = rdy;
    r.exp_rdata = er; r.exp_irq = ei; r.exp_valid = ev; r.exp_data = ed; r.exp_ctrl = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [9:0] wa, input logic [31:0] wd, input logic re,
                       input logic [9:0] ra, input logic [7:0] is, input logic rdy);
    WE = we; WADDR = wa; WDATA = wd; RE = re; RADDR = ra; IRQ_SET = is; CMD_READY = rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    localparam logic [31:0] C = 32'hA5A5_0F0F;
    tv[0]  = v(0, 0, 0, 1, 10'h000, 0, 0, 32'h5244_0001, 0, 0, 0, 0);
    tv[1]  = v(0, 0, 0, 1, 10'h3FF, 0, 0, 0, 0, 0, 0, 0);
    tv[2]  = v(1, 10'h001, C, 1, 10'h001, 0, 0, 0, 0, 0, 0, C);
    tv[3]  = v(0, 0, 0, 1, 10'h001, 0, 0, C, 0, 0, 0, C);
    tv[4]  = v(1, 10'h012, 32'h1234_5678, 0, 0, 0, 0, C, 0, 0, 0, C);
    tv[5]  = v(0, 0, 0, 1, 10'h012, 0, 0, 32'h1234_5678, 0, 0, 0, C);
    tv[6]  = v(1, 10'h018, 32'hDEAD_BEEF, 1, 10'h017, 0, 0, 0, 0, 0, 0, C);
    tv[7]  = v(0, 0, 0, 1, 10'h018, 0, 0, 0, 0, 0, 0, C);
    tv[8]  = v(1, 10'h006, 1, 0, 0, 0, 0, 0, 0, 1, 1, C);
    tv[9]  = v(1, 10'h006, 2, 0, 0, 0, 0, 0, 0, 1, 1, C);
    tv[10] = v(1, 10'h006, 3, 0, 0, 0, 0, 0, 0, 1, 1, C);
    tv[11] = v(1, 10'h006, 4, 0, 0, 0, 0, 0, 0, 1, 1, C);
    tv[12] = v(1, 10'h006, 5, 0, 0, 0, 0, 0, 0, 1, 1, C);
    tv[13] = v(0, 0, 0, 1, 10'h002, 0, 0, 32'h406, 0, 1, 1, C);
    tv[14] = v(1, 10'h002, 4, 1, 10'h006, 0, 0, 0, 0, 1, 1, C);
    tv[15] = v(0, 0, 0, 1, 10'h002, 0, 0, 32'h402, 0, 1, 1, C);
    tv[16] = v(1, 10'h006, 6, 0, 0, 0, 1, 32'h402, 0, 1, 2, C);
    tv[17] = v(0, 0, 0, 1, 10'h002, 0, 0, 32'h402, 0, 1, 2, C);
    tv[18] = v(0, 0, 0, 0, 0, 0, 1, 32'h402, 0, 1, 3, C);
    tv[19] = v(0, 0, 0, 0, 0, 0, 1, 32'h402, 0, 1, 4, C);
    tv[20] = v(0, 0, 0, 0, 0, 0, 1, 32'h402, 0, 1, 6, C);
    tv[21] = v(0, 0, 0, 0, 0, 0, 1, 32'h402, 0, 0, 0, C);
    tv[22] = v(0, 0, 0, 1, 10'h002, 0, 0, 32'h1, 0, 0, 0, C);
    tv[23] = v(1, 10'h004, 1, 0, 0, 0, 0, 32'h1, 0, 0, 0, C);
    tv[24] = v(0, 0, 0, 0, 0, 8'h01, 0, 32'h1, 0, 0, 0, C);
    tv[25] = v(0, 0, 0, 0, 0, 0, 0, 32'h1, 1, 0, 0, C);
    tv[26] = v(1, 10'h003, 1, 0, 0, 8'h01, 0, 32'h1, 1, 0, 0, C);
    tv[27] = v(0, 0, 0, 1, 10'h003, 0, 0, 32'h1, 1, 0, 0, C);
    tv[28] = v(1, 10'h003, 1, 0, 0, 0, 0, 32'h1, 1, 0, 0, C);
    tv[29] = v(0, 0, 0, 1, 10'h002, 0, 0, 32'h9, 0, 0, 0, C);
    tv[30] = v(0, 0, 0, 1, 10'h003, 0, 0, 32'h0, 0, 0, 0, C);
    tv[31] = v(0, 0, 0, 0, 0, 8'h02, 0, 32'h0, 0, 0, 0, C);
    tv[32] = v(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, C);
    tv[33] = v(0, 0, 0, 1, 10'h003, 0, 0, 32'h2, 0, 0, 0, C);

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_rdata", RDATA, 0);
    chk("reset_irq", 32'(IRQ), 0);
    chk("reset_valid", 32'(CMD_VALID), 0);
    chk("reset_ctrl", CTRL, 0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 34; i++) begin
      @(negedge CLK);
      drive(tv[i].we, tv[i].waddr, tv[i].wdata, tv[i].re, tv[i].raddr, tv[i].irq_set, tv[i].ready);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_rdata", i), RDATA, tv[i].exp_rdata);
      chk($sformatf("v%0d_irq", i), 32'(IRQ), 32'(tv[i].exp_irq));
      chk($sformatf("v%0d_valid", i), 32'(CMD_VALID), 32'(tv[i].exp_valid));
      chk($sformatf("v%0d_ctrl", i), CTRL, tv[i].exp_ctrl);
      if (tv[i].exp_valid) chk($sformatf("v%0d_cmd_data", i), CMD_DATA, tv[i].exp_data);
    end

    // Reset lands between a read request and its data; a queued command is flushed too.
    @(negedge CLK);
    drive(1, 10'h006, 32'h77, 0, 0, 0, 0);
    @(negedge CLK);
    drive(0, 0, 0, 1, 10'h000, 0, 0);
    #2 nRST = 1'b0;
    #1;
    chk("midreset_valid_async", 32'(CMD_VALID), 0);
    @(posedge CLK);
    #1;
    chk("midreset_rdata", RDATA, 0);
    chk("midreset_ctrl", CTRL, 0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    chk("postreset_rdata", RDATA, 0);
    chk("postreset_valid", 32'(CMD_VALID), 0);

    @(negedge CLK);
    drive(1, 10'h005, 32'hFFFF, 0, 0, 0, 0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    drive(0, 0, 0, 1, 10'h005, 0, 0);
    @(posedge CLK);
    #1;
`ifdef TESTDRIVE_VIRTUAL_SLAVE_REGBANK_CYCLE_EN
    chk("cycle_after_load", RDATA, 32'h1);
`else
    chk("cycle_absent", RDATA, 32'h0);
`endif
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
